// File: rtl/ibex_avalon_flash_bridge.sv
// Bridges the Ibex instruction and data ports onto one Avalon-MM master for a flash ROM controller.
// Commands are registered onto av_*, and read responses are routed back in order through a small tag FIFO.
module ibex_avalon_flash_bridge #(
    parameter int unsigned AV_AW           = 24,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned SWAP_BYTES      = 1,
    parameter int unsigned ALLOW_WRITE     = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             instr_req_i,
    input  logic [31:0]      instr_addr_i,
    output logic             instr_gnt_o,
    output logic             instr_rvalid_o,
    output logic [31:0]      instr_rdata_o,

    input  logic             data_req_i,
    input  logic             data_we_i,
    input  logic [3:0]       data_be_i,
    input  logic [31:0]      data_addr_i,
    input  logic [31:0]      data_wdata_i,
    output logic             data_gnt_o,
    output logic             data_rvalid_o,
    output logic [31:0]      data_rdata_o,
    output logic             data_err_o,

    output logic [AV_AW-1:0] av_address_o,
    output logic             av_read_o,
    output logic             av_write_o,
    output logic [31:0]      av_writedata_o,
    output logic [3:0]       av_byteenable_o,
    output logic             av_burstcount_o,
    input  logic             av_waitrequest_i,
    input  logic [31:0]      av_readdata_i,
    input  logic             av_readdatavalid_i,

    output logic             spurious_o
);

    typedef enum logic {
        IDLE = 1'b0,
        CMD  = 1'b1
    } state_e;

    localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);
    localparam bit         WR_EN   = (ALLOW_WRITE != 0);

    state_e           state_q;
    logic [AV_AW-1:0] av_address_q;
    logic             av_read_q;
    logic             av_write_q;
    logic [31:0]      av_writedata_q;
    logic [3:0]       av_byteenable_q;
    logic             src_data_q;
    logic             wr_rsp_q;

    logic             tag_mem_q [4];
    logic [1:0]       wr_ptr_q;
    logic [1:0]       rd_ptr_q;
    logic [2:0]       cnt_q;

    logic             instr_rvalid_q;
    logic [31:0]      instr_rdata_q;
    logic             data_rvalid_q;
    logic [31:0]      data_rdata_q;
    logic             data_err_q;
    logic             spurious_q;

    logic [31:0]      rdata_sw;
    logic [31:0]      wdata_sw;
    logic [3:0]       be_sw;

    // Flash words are stored big-endian, so lanes are mirrored on the way in and out.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            if (SWAP_BYTES != 0) begin : g_swap
                assign rdata_sw[8*gi +: 8] = av_readdata_i[8*(3-gi) +: 8];
                assign wdata_sw[8*gi +: 8] = data_wdata_i[8*(3-gi) +: 8];
                assign be_sw[gi]           = data_be_i[3-gi];
            end else begin : g_pass
                assign rdata_sw[8*gi +: 8] = av_readdata_i[8*gi +: 8];
                assign wdata_sw[8*gi +: 8] = data_wdata_i[8*gi +: 8];
                assign be_sw[gi]           = data_be_i[gi];
            end
        end
    endgenerate

    logic can_read;
    logic can_write;
    logic issue_data_rd;
    logic issue_data_wr;
    logic issue_instr;
    logic local_wr;
    logic accept;
    logic push;
    logic pop;

    assign can_read      = (cnt_q < MAX_CNT);
    assign can_write     = (cnt_q == 3'd0) && !wr_rsp_q;
    assign issue_data_rd = (state_q == IDLE) && data_req_i && !data_we_i && can_read;
    assign issue_data_wr = (state_q == IDLE) && data_req_i && data_we_i && can_write && WR_EN;
    assign local_wr      = (state_q == IDLE) && data_req_i && data_we_i && can_write && !WR_EN;
    assign issue_instr   = (state_q == IDLE) && !data_req_i && instr_req_i && can_read;
    assign accept        = (state_q == CMD) && !av_waitrequest_i;
    assign push          = accept && av_read_q;
    assign pop           = av_readdatavalid_i && (cnt_q != 3'd0);

    assign instr_gnt_o = accept && !src_data_q;
    assign data_gnt_o  = (accept && src_data_q) || local_wr;

    always_ff @(posedge clk_i) begin
        if (push) begin
            tag_mem_q[wr_ptr_q] <= src_data_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            av_address_q    <= '0;
            av_read_q       <= 1'b0;
            av_write_q      <= 1'b0;
            av_writedata_q  <= '0;
            av_byteenable_q <= '0;
            src_data_q      <= 1'b0;
            wr_rsp_q        <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            cnt_q           <= '0;
            instr_rvalid_q  <= 1'b0;
            instr_rdata_q   <= '0;
            data_rvalid_q   <= 1'b0;
            data_rdata_q    <= '0;
            data_err_q      <= 1'b0;
            spurious_q      <= 1'b0;
        end else begin
            instr_rvalid_q <= 1'b0;
            data_rvalid_q  <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (issue_data_rd || issue_data_wr || issue_instr) begin
                        state_q         <= CMD;
                        av_read_q       <= !issue_data_wr;
                        av_write_q      <= issue_data_wr;
                        src_data_q      <= !issue_instr;
                        av_address_q    <= issue_instr ? instr_addr_i[AV_AW+1:2]
                                                       : data_addr_i[AV_AW+1:2];
                        av_byteenable_q <= issue_data_wr ? be_sw : 4'hF;
                        if (issue_data_wr) begin
                            av_writedata_q <= wdata_sw;
                        end
                    end
                end
                CMD: begin
                    if (!av_waitrequest_i) begin
                        state_q    <= IDLE;
                        av_read_q  <= 1'b0;
                        av_write_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Write responses: one cycle after Avalon acceptance, or after a locally refused write.
            wr_rsp_q <= (accept && av_write_q) || local_wr;
            if ((accept && av_write_q) || local_wr) begin
                data_rvalid_q <= 1'b1;
                data_err_q    <= local_wr;
            end

            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
                if (tag_mem_q[rd_ptr_q]) begin
                    data_rvalid_q <= 1'b1;
                    data_rdata_q  <= rdata_sw;
                    data_err_q    <= 1'b0;
                end else begin
                    instr_rvalid_q <= 1'b1;
                    instr_rdata_q  <= rdata_sw;
                end
            end else if (av_readdatavalid_i) begin
                spurious_q <= 1'b1;
            end

            if (push) begin
                wr_ptr_q <= wr_ptr_q + 2'd1;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 3'd1;
                2'b01:   cnt_q <= cnt_q - 3'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    logic unused_addr_bits;
    assign unused_addr_bits = ^{instr_addr_i, data_addr_i};

    assign instr_rvalid_o  = instr_rvalid_q;
    assign instr_rdata_o   = instr_rdata_q;
    assign data_rvalid_o   = data_rvalid_q;
    assign data_rdata_o    = data_rdata_q;
    assign data_err_o      = data_err_q;
    assign av_address_o    = av_address_q;
    assign av_read_o       = av_read_q;
    assign av_write_o      = av_write_q;
    assign av_writedata_o  = av_writedata_q;
    assign av_byteenable_o = av_byteenable_q;
    assign av_burstcount_o = 1'b1;
    assign spurious_o      = spurious_q;

endmodule

// File: tb/tb_ibex_avalon_flash_bridge.sv
// Directed bench for ibex_avalon_flash_bridge: a read-only instance (defaults) and a write-enabled instance.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_ibex_avalon_flash_bridge;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    // Read-only instance (ALLOW_WRITE=0)
    logic        instr_req, data_req, data_we, av_wait, av_rvalid;
    logic [31:0] instr_addr, data_addr, data_wdata, av_rdata;
    logic [3:0]  data_be;
    logic        instr_gnt, instr_rvalid, data_gnt, data_rvalid, data_err;
    logic [31:0] instr_rdata, data_rdata, av_wdata;
    logic [23:0] av_address;
    logic        av_read, av_write, av_burst, spurious;
    logic [3:0]  av_be;

    // Write-enabled instance (ALLOW_WRITE=1)
    logic        w_instr_req, w_data_req, w_data_we, w_av_wait, w_av_rvalid;
    logic [31:0] w_instr_addr, w_data_addr, w_data_wdata, w_av_rdata;
    logic [3:0]  w_data_be;
    logic        w_instr_gnt, w_instr_rvalid, w_data_gnt, w_data_rvalid, w_data_err;
    logic [31:0] w_instr_rdata, w_data_rdata, w_av_wdata;
    logic [23:0] w_av_address;
    logic        w_av_read, w_av_write, w_av_burst, w_spurious;
    logic [3:0]  w_av_be;

    ibex_avalon_flash_bridge u_ro (
        .clk_i(clk), .rst_ni(rst_n),
        .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt),
        .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata),
        .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be),
        .data_addr_i(data_addr), .data_wdata_i(data_wdata), .data_gnt_o(data_gnt),
        .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata), .data_err_o(data_err),
        .av_address_o(av_address), .av_read_o(av_read), .av_write_o(av_write),
        .av_writedata_o(av_wdata), .av_byteenable_o(av_be), .av_burstcount_o(av_burst),
        .av_waitrequest_i(av_wait), .av_readdata_i(av_rdata),
        .av_readdatavalid_i(av_rvalid), .spurious_o(spurious)
    );

    ibex_avalon_flash_bridge #(.ALLOW_WRITE(1)) u_rw (
        .clk_i(clk), .rst_ni(rst_n),
        .instr_req_i(w_instr_req), .instr_addr_i(w_instr_addr), .instr_gnt_o(w_instr_gnt),
        .instr_rvalid_o(w_instr_rvalid), .instr_rdata_o(w_instr_rdata),
        .data_req_i(w_data_req), .data_we_i(w_data_we), .data_be_i(w_data_be),
        .data_addr_i(w_data_addr), .data_wdata_i(w_data_wdata), .data_gnt_o(w_data_gnt),
        .data_rvalid_o(w_data_rvalid), .data_rdata_o(w_data_rdata), .data_err_o(w_data_err),
        .av_address_o(w_av_address), .av_read_o(w_av_read), .av_write_o(w_av_write),
        .av_writedata_o(w_av_wdata), .av_byteenable_o(w_av_be), .av_burstcount_o(w_av_burst),
        .av_waitrequest_i(w_av_wait), .av_readdata_i(w_av_rdata),
        .av_readdatavalid_i(w_av_rvalid), .spurious_o(w_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
        $display("[TB] check %-22s observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests = 0; fails = 0;
        rst_n = 1'b0;
        instr_req = 0; instr_addr = '0; data_req = 0; data_we = 0; data_be = '0;
        data_addr = '0; data_wdata = '0; av_wait = 0; av_rvalid = 0; av_rdata = '0;
        w_instr_req = 0; w_instr_addr = '0; w_data_req = 0; w_data_we = 0; w_data_be = '0;
        w_data_addr = '0; w_data_wdata = '0; w_av_wait = 0; w_av_rvalid = 0; w_av_rdata = '0;

        // Reset state
        cyc(); cyc(); #1;
        chk("rst_ctrl", 32'({instr_gnt, instr_rvalid, data_gnt, data_rvalid, data_err,
                              av_read, av_write, spurious}), 32'h0);
        chk("rst_instr_rdata", instr_rdata, 32'h0);
        chk("rst_data_rdata", data_rdata, 32'h0);
        chk("rst_av_address", 32'(av_address), 32'h0);
        chk("rst_av_wdata_be", 32'({av_wdata[27:0], av_be}), 32'h0);
        chk("rst_w_ctrl", 32'({w_instr_gnt, w_instr_rvalid, w_data_gnt, w_data_rvalid,
                                w_av_read, w_av_write, w_spurious}), 32'h0);
        cyc(); rst_n = 1'b1;

        // Single fetch, two waitrequest cycles
        cyc(); instr_req = 1; instr_addr = 32'h80; av_wait = 1; #1;
        chk("t1_gnt_idle", 32'(instr_gnt), 32'h0);
        cyc(); #1;
        chk("t1_av_read", 32'(av_read), 32'h1);
        chk("t1_av_address", 32'(av_address), 32'h20);
        chk("t1_av_be", 32'(av_be), 32'hF);
        chk("t1_gnt_wait1", 32'(instr_gnt), 32'h0);
        cyc(); #1;
        chk("t1_gnt_wait2", 32'({instr_gnt, av_read}), 32'h1);
        cyc(); av_wait = 0; #1;
        chk("t1_gnt", 32'({instr_gnt, data_gnt}), 32'h2);
        cyc(); instr_req = 0; #1;
        chk("t1_read_drop", 32'({instr_gnt, av_read}), 32'h0);
        cyc(); av_rvalid = 1; av_rdata = 32'h13000000; #1;
        chk("t1_rvalid_early", 32'(instr_rvalid), 32'h0);
        cyc(); av_rvalid = 0; #1;
        chk("t1_rvalid", 32'({instr_rvalid, data_rvalid}), 32'h2);
        chk("t1_rdata", instr_rdata, 32'h00000013);
        cyc(); #1;
        chk("t1_rvalid_pulse", 32'(instr_rvalid), 32'h0);
        chk("t1_rdata_hold", instr_rdata, 32'h00000013);

        // Simultaneous data and instr reads
        cyc(); instr_req = 1; instr_addr = 32'h100;
        data_req = 1; data_we = 0; data_be = 4'hF; data_addr = 32'h204; #1;
        chk("t2_no_gnt_idle", 32'({instr_gnt, data_gnt}), 32'h0);
        cyc(); #1;
        chk("t2_data_addr", 32'(av_address), 32'h81);
        chk("t2_data_first", 32'({instr_gnt, data_gnt}), 32'h1);
        cyc(); data_req = 0; #1;
        chk("t2_gap", 32'(av_read), 32'h0);
        cyc(); #1;
        chk("t2_instr_addr", 32'(av_address), 32'h40);
        chk("t2_instr_gnt", 32'({instr_gnt, data_gnt}), 32'h2);
        cyc(); instr_req = 0; av_rvalid = 1; av_rdata = 32'h11223344; #1;
        cyc(); av_rdata = 32'hAABBCCDD; #1;
        chk("t2_data_rvalid", 32'({data_rvalid, instr_rvalid, data_err}), 32'h4);
        chk("t2_data_rdata", data_rdata, 32'h44332211);
        cyc(); av_rvalid = 0; #1;
        chk("t2_instr_rvalid", 32'({data_rvalid, instr_rvalid}), 32'h1);
        chk("t2_instr_rdata", instr_rdata, 32'hDDCCBBAA);

        // Outstanding limit of two
        cyc(); instr_req = 1; instr_addr = 32'h300; #1;
        cyc(); #1;
        chk("t3_gnt1", 32'(instr_gnt), 32'h1);
        cyc(); #1;
        chk("t3_gap1", 32'(av_read), 32'h0);
        cyc(); #1;
        chk("t3_gnt2", 32'(instr_gnt), 32'h1);
        cyc(); #1;
        chk("t3_blocked", 32'(av_read), 32'h0);
        cyc(); av_rvalid = 1; av_rdata = 32'h01000000; #1;
        chk("t3_blocked2", 32'({av_read, instr_gnt}), 32'h0);
        cyc(); av_rvalid = 0; #1;
        chk("t3_rsp1", 32'({instr_rvalid, av_read}), 32'h2);
        chk("t3_rdata1", instr_rdata, 32'h00000001);
        cyc(); #1;
        chk("t3_third", 32'({av_read, instr_gnt}), 32'h3);
        cyc(); instr_req = 0; av_rvalid = 1; av_rdata = 32'h02000000; #1;
        cyc(); av_rdata = 32'h03000000; #1;
        chk("t3_rdata2", instr_rdata, 32'h00000002);
        cyc(); av_rvalid = 0; #1;
        chk("t3_rdata3", instr_rdata, 32'h00000003);
        chk("t3_rvalid3", 32'(instr_rvalid), 32'h1);

        // Write refused locally
        cyc(); data_req = 1; data_we = 1; data_be = 4'hF; data_addr = 32'h400;
        data_wdata = 32'hDEADBEEF; #1;
        chk("t4_gnt", 32'({data_gnt, av_write}), 32'h2);
        cyc(); data_req = 0; data_we = 0; #1;
        chk("t4_err_rsp", 32'({data_rvalid, data_err}), 32'h3);
        chk("t4_no_avalon", 32'({av_read, av_write}), 32'h0);
        cyc(); #1;
        chk("t4_rvalid_pulse", 32'({data_rvalid, av_write}), 32'h0);
        chk("t4_wdata_unused", av_wdata, 32'h0);

        // Write waits behind an outstanding read, lanes mirrored
        cyc(); w_data_req = 1; w_data_we = 0; w_data_be = 4'hF; w_data_addr = 32'h10; #1;
        cyc(); #1;
        chk("t5_rd_gnt", 32'({w_data_gnt, w_av_read}), 32'h3);
        cyc(); w_data_we = 1; w_data_be = 4'b0001; w_data_addr = 32'h20;
        w_data_wdata = 32'h12345678; #1;
        chk("t5_wr_held1", 32'({w_data_gnt, w_av_write}), 32'h0);
        cyc(); w_av_rvalid = 1; w_av_rdata = 32'hCAFEF00D; #1;
        chk("t5_wr_held2", 32'({w_data_gnt, w_av_write}), 32'h0);
        cyc(); w_av_rvalid = 0; #1;
        chk("t5_rd_rsp", 32'({w_data_rvalid, w_data_err, w_av_write}), 32'h4);
        chk("t5_rd_rdata", w_data_rdata, 32'h0DF0FECA);
        cyc(); #1;
        chk("t5_wr_issue", 32'({w_av_write, w_data_gnt, w_data_rvalid}), 32'h6);
        chk("t5_wr_be", 32'(w_av_be), 32'h8);
        chk("t5_wr_wdata", w_av_wdata, 32'h78563412);
        chk("t5_wr_addr", 32'(w_av_address), 32'h8);
        cyc(); w_data_req = 0; w_data_we = 0; #1;
        chk("t5_wr_rsp", 32'({w_data_rvalid, w_data_err, w_av_write}), 32'h4);

        // Spurious readdatavalid, reset mid-command
        cyc(); av_rvalid = 1; av_rdata = 32'h00000055; #1;
        chk("t6_spur_before", 32'(spurious), 32'h0);
        cyc(); av_rvalid = 0; #1;
        chk("t6_spur_set", 32'({spurious, instr_rvalid, data_rvalid}), 32'h4);
        cyc(); rst_n = 0; #1;
        chk("t6_spur_clear", 32'(spurious), 32'h0);
        cyc(); rst_n = 1;
        cyc(); instr_req = 1; instr_addr = 32'h80; av_wait = 1;
        cyc(); #1;
        chk("t6_cmd", 32'(av_read), 32'h1);
        cyc(); rst_n = 0; #1;
        chk("t6_rst_cmd", 32'({av_read, instr_gnt}), 32'h0);
        chk("t6_rst_addr", 32'(av_address), 32'h0);
        cyc(); rst_n = 1; instr_req = 0; av_wait = 0;
        cyc(); av_rvalid = 1; av_rdata = 32'h13000000;
        cyc(); av_rvalid = 0; #1;
        chk("t6_late_spur", 32'({spurious, instr_rvalid}), 32'h2);
        cyc(); rst_n = 0; #1;
        chk("t6_final_ctrl", 32'({instr_gnt, instr_rvalid, data_gnt, data_rvalid, data_err,
                                   av_read, av_write, spurious}), 32'h0);
        chk("t6_final_rdata", instr_rdata | data_rdata, 32'h0);
        cyc(); rst_n = 1;
        cyc(); #1;
        chk("t6_idle", 32'({av_read, av_write, instr_gnt, data_gnt}), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
